// File: rtl/simmem_pkg.sv
// Shared types for the simulated memory write path.
package simmem_pkg;

  localparam int unsigned MaxBurstLenField = 2;
  localparam int unsigned IDWidth          = 2;
  localparam int unsigned XRespWidth       = 10;

  localparam int unsigned BurstLenWidth = 3;
  localparam int unsigned AddrWidth     = 16;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned StrbWidth     = DataWidth / 8;

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_len;  // log2 of the beat count
  } waddr_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strobes;
    logic                 last;
  } wdata_t;

  typedef struct packed {
    logic [IDWidth-1:0]    id;
    logic [XRespWidth-1:0] payload;  // {seq_cnt[7:0], resp[1:0]}
  } wrsp_t;

endpackage

// File: rtl/simmem_wrsp_responder.sv
// Memory-side write responder: buffers write addresses, consumes the matching
// write-data bursts and returns one in-order write response per burst.
module simmem_wrsp_responder
  import simmem_pkg::*;
#(
  parameter int unsigned AwFifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [$bits(waddr_t)-1:0] waddr_i,
  input  logic                 waddr_in_valid_i,
  output logic                 waddr_in_ready_o,
  input  logic [$bits(wdata_t)-1:0] wdata_i,
  input  logic                 wdata_in_valid_i,
  output logic                 wdata_in_ready_o,
  output logic [$bits(wrsp_t)-1:0]  wrsp_o,
  output logic                 wrsp_out_valid_o,
  input  logic                 wrsp_out_ready_i
);

  localparam int unsigned PtrW  = $clog2(AwFifoDepth);
  localparam int unsigned BeatW = MaxBurstLenField + 1;

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [BurstLenWidth-1:0] burst_len;
  } aw_entry_t;

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  waddr_t waddr;
  wdata_t wdata;
  wrsp_t  wrsp;

  assign waddr  = waddr_t'(waddr_i);
  assign wdata  = wdata_t'(wdata_i);
  assign wrsp_o = wrsp;

  // Address and data payload are not needed to build a response.
  logic unused_payload;
  assign unused_payload = ^{waddr.addr, wdata.data, wdata.strobes};

  aw_entry_t         mem_q [AwFifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic              aw_ready_q;
  aw_entry_t         head;

  state_e             state_q, state_d;
  logic [IDWidth-1:0] cur_id_q;
  logic [BurstLenWidth-1:0] cur_len_q;
  logic               err_q;
  logic [BeatW-1:0]   beat_cnt_q;
  logic [7:0]         seq_cnt_q;

  logic             aw_push, pop, w_hs, rsp_hs, fifo_empty;
  logic [BeatW-1:0] beats_n, beat_cnt_inc;
  logic             is_nth;

  assign waddr_in_ready_o = aw_ready_q;
  assign aw_push    = waddr_in_valid_i && aw_ready_q;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign w_hs       = wdata_in_valid_i && wdata_in_ready_o;
  assign rsp_hs     = wrsp_out_valid_o && wrsp_out_ready_i;

  // Beats expected for the current burst, clamped to the largest legal burst.
  always_comb begin
    if (cur_len_q > BurstLenWidth'(MaxBurstLenField)) begin
      beats_n = BeatW'(1) << MaxBurstLenField;
    end else begin
      beats_n = BeatW'(1) << cur_len_q;
    end
    beat_cnt_inc = beat_cnt_q + BeatW'(1);
    is_nth       = (beat_cnt_inc == beats_n);
  end

  // FIFO occupancy; push and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({aw_push, pop})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (aw_push) begin
      mem_q[wr_ptr_q] <= '{id: waddr.id, burst_len: waddr.burst_len};
    end
  end

  // FIFO pointers, occupancy and the registered not-full ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      aw_ready_q <= 1'b0;
    end else begin
      if (aw_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      aw_ready_q <= (count_d != (PtrW+1)'(AwFifoDepth));
    end
  end

  // Next state, pop request, channel handshakes and the response word.
  always_comb begin
    state_d          = state_q;
    pop              = 1'b0;
    wdata_in_ready_o = 1'b0;
    wrsp_out_valid_o = 1'b0;
    wrsp             = '0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        wdata_in_ready_o = 1'b1;
        if (w_hs && is_nth) state_d = StResp;
      end
      StResp: begin
        wrsp_out_valid_o = 1'b1;
        wrsp.id          = cur_id_q;
        wrsp.payload     = {seq_cnt_q, (err_q ? 2'b10 : 2'b00)};
        if (wrsp_out_ready_i) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state plus the per-burst context, beat counter and response sequence.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cur_id_q   <= '0;
      cur_len_q  <= '0;
      err_q      <= 1'b0;
      beat_cnt_q <= '0;
      seq_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        cur_id_q   <= head.id;
        cur_len_q  <= head.burst_len;
        err_q      <= (head.burst_len > BurstLenWidth'(MaxBurstLenField));
        beat_cnt_q <= '0;
      end else if (w_hs) begin
        beat_cnt_q <= beat_cnt_inc;
        // last must be set exactly on the final beat
        if (wdata.last != is_nth) err_q <= 1'b1;
      end
      if (rsp_hs) seq_cnt_q <= seq_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_simmem_wrsp_responder.sv
// Directed bench for the write responder with hand-computed responses.
module tb_simmem_wrsp_responder;
  import simmem_pkg::*;

  logic   clk = 1'b0;
  logic   rst_ni;
  waddr_t waddr;
  wdata_t wdata;
  logic   waddr_in_valid, waddr_in_ready;
  logic   wdata_in_valid, wdata_in_ready;
  wrsp_t  wrsp;
  logic   wrsp_out_valid, wrsp_out_ready;

  int n_checks = 0;
  int n_bad    = 0;

  wrsp_t rsp_q[$];

  simmem_wrsp_responder #(.AwFifoDepth(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .waddr_i          (waddr),
    .waddr_in_valid_i (waddr_in_valid),
    .waddr_in_ready_o (waddr_in_ready),
    .wdata_i          (wdata),
    .wdata_in_valid_i (wdata_in_valid),
    .wdata_in_ready_o (wdata_in_ready),
    .wrsp_o           (wrsp),
    .wrsp_out_valid_o (wrsp_out_valid),
    .wrsp_out_ready_i (wrsp_out_ready)
  );

  always #5 clk = ~clk;

  // Record every response handshake; inputs only move just after rising edges.
  always @(negedge clk) begin
    if (rst_ni && wrsp_out_valid && wrsp_out_ready) rsp_q.push_back(wrsp);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic wrsp_t exp_rsp(input logic [1:0] id, input logic [7:0] seq,
                                    input logic err);
    wrsp_t r;
    r.id      = id;
    r.payload = {seq, (err ? 2'b10 : 2'b00)};
    return r;
  endfunction

  task automatic send_aw(input logic [1:0] id, input logic [2:0] len);
    waddr.id        = id;
    waddr.addr      = 16'($urandom);
    waddr.burst_len = len;
    waddr_in_valid  = 1'b1;
    for (int t = 0; t < 200 && !waddr_in_ready; t++) @(negedge clk);
    if (!waddr_in_ready) begin
      check("aw_ready_wait", 32'(waddr_in_ready), 32'd1);
      waddr_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 waddr_in_valid = 1'b0;
  endtask

  task automatic send_w(input logic last);
    wdata.data     = $urandom;
    wdata.strobes  = 4'($urandom);
    wdata.last     = last;
    wdata_in_valid = 1'b1;
    for (int t = 0; t < 200 && !wdata_in_ready; t++) @(negedge clk);
    if (!wdata_in_ready) begin
      check("w_ready_wait", 32'(wdata_in_ready), 32'd1);
      wdata_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 wdata_in_valid = 1'b0;
  endtask

  task automatic send_burst(input int beats);
    for (int b = 0; b < beats; b++) send_w(b == beats - 1);
  endtask

  task automatic wait_rsps(input string tag, input int n);
    for (int t = 0; t < 3000 && rsp_q.size() < n; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(tag, 32'(rsp_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    waddr_in_valid = 1'b0;
    wdata_in_valid = 1'b0;
    wrsp_out_ready = 1'b1;
    rst_ni         = 1'b0;
    repeat (2) @(posedge clk);
    rsp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] bp_id  [5];
    int         bp_len [5];
    bp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    bp_len = '{0, 1, 0, 2, 0};

    rst_ni         = 1'b1;
    waddr          = '0;
    wdata          = '0;
    waddr_in_valid = 1'b0;
    wdata_in_valid = 1'b0;
    wrsp_out_ready = 1'b1;

    // Reset values and ready rising on the first edge after release
    #1 rst_ni = 1'b0;
    #1;
    check("rst_aw_ready", 32'(waddr_in_ready), 32'd0);
    check("rst_w_ready",  32'(wdata_in_ready), 32'd0);
    check("rst_rsp_valid", 32'(wrsp_out_valid), 32'd0);
    check("rst_rsp",      32'(wrsp), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1 check("rel_aw_ready_pre_edge", 32'(waddr_in_ready), 32'd0);
    @(posedge clk);
    #1 check("rel_aw_ready_post_edge", 32'(waddr_in_ready), 32'd1);

    // Single two-beat burst with latency checks
    send_aw(2'd1, 3'd1);
    @(negedge clk) check("lat_w_ready_c1", 32'(wdata_in_ready), 32'd0);
    @(negedge clk) check("lat_w_ready_c2", 32'(wdata_in_ready), 32'd1);
    send_w(1'b0);
    send_w(1'b1);
    @(negedge clk);
    check("lat_rsp_valid", 32'(wrsp_out_valid), 32'd1);
    check("single_rsp_now", 32'(wrsp), 32'(exp_rsp(2'd1, 8'd0, 1'b0)));
    wait_rsps("single_count", 1);
    if (rsp_q.size() == 1) check("single_rsp", 32'(rsp_q[0]), 32'(exp_rsp(2'd1, 8'd0, 1'b0)));

    // Back-pressure: the first AW is popped straight into DATA, so the
    // four-deep FIFO fills on the fifth push.
    do_reset();
    wrsp_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_aw(bp_id[i], 3'(bp_len[i]));
      if (i == 3) check("bp_ready_after_4", 32'(waddr_in_ready), 32'd1);
    end
    check("bp_ready_full", 32'(waddr_in_ready), 32'd0);
    send_burst(1 << bp_len[0]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(wrsp_out_valid), 32'd1);
      check("bp_hold_rsp", 32'(wrsp), 32'(exp_rsp(bp_id[0], 8'd0, 1'b0)));
    end
    @(posedge clk);
    #1 wrsp_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) send_burst(1 << bp_len[i]);
    wait_rsps("bp_count", 5);
    for (int i = 0; i < 5 && i < rsp_q.size(); i++)
      check($sformatf("bp_rsp%0d", i), 32'(rsp_q[i]), 32'(exp_rsp(bp_id[i], 8'(i), 1'b0)));

    // Early last on beat 2 of 4: burst still takes four beats, then SLVERR
    do_reset();
    send_aw(2'd2, 3'd2);
    send_w(1'b0);
    send_w(1'b1);
    check("lm_still_ready", 32'(wdata_in_ready), 32'd1);
    send_w(1'b0);
    send_w(1'b0);
    check("lm_ready_done", 32'(wdata_in_ready), 32'd0);
    wait_rsps("lm_count", 1);
    if (rsp_q.size() == 1) check("lm_rsp", 32'(rsp_q[0]), 32'(exp_rsp(2'd2, 8'd0, 1'b1)));

    // Oversized length clamps to four beats with SLVERR; next burst is clean
    do_reset();
    send_aw(2'd3, 3'd5);
    send_burst(3);
    check("ov_ready_beat3", 32'(wdata_in_ready), 32'd1);
    send_w(1'b1);
    check("ov_ready_done", 32'(wdata_in_ready), 32'd0);
    send_aw(2'd0, 3'd0);
    send_burst(1);
    wait_rsps("ov_count", 2);
    if (rsp_q.size() == 2) begin
      check("ov_rsp_err", 32'(rsp_q[0]), 32'(exp_rsp(2'd3, 8'd0, 1'b1)));
      check("ov_rsp_ok",  32'(rsp_q[1]), 32'(exp_rsp(2'd0, 8'd1, 1'b0)));
    end

    // Sequence counter wraps 255 -> 0
    do_reset();
    for (int i = 0; i < 257; i++) begin
      send_aw(2'(i), 3'd0);
      send_w(1'b1);
    end
    wait_rsps("wrap_count", 257);
    for (int i = 0; i < 257 && i < rsp_q.size(); i++)
      check($sformatf("wrap_rsp%0d", i), 32'(rsp_q[i]), 32'(exp_rsp(2'(i), 8'(i), 1'b0)));

    // Reset in the middle of a four-beat burst
    do_reset();
    send_aw(2'd1, 3'd2);
    send_w(1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_aw_ready",  32'(waddr_in_ready), 32'd0);
    check("mid_w_ready",   32'(wdata_in_ready), 32'd0);
    check("mid_rsp_valid", 32'(wrsp_out_valid), 32'd0);
    check("mid_rsp",       32'(wrsp), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1 check("mid_rel_aw_ready", 32'(waddr_in_ready), 32'd1);
    rsp_q.delete();
    send_aw(2'd2, 3'd0);
    send_w(1'b1);
    wait_rsps("mid_count", 1);
    if (rsp_q.size() == 1) check("mid_rsp_after", 32'(rsp_q[0]), 32'(exp_rsp(2'd2, 8'd0, 1'b0)));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
